// File: rtl/aip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aip_pkg
// Description : Shared config codes, STATUS field positions and FSM states
//               for the AIP host responder.
// Revision    : 1.0 - initial release
// ============================================================================
package aip_pkg;

    localparam logic [4:0] MDATAINX = 5'd0;
    localparam logic [4:0] ADATAINX = 5'd1;
    localparam logic [4:0] MDATAINY = 5'd2;
    localparam logic [4:0] ADATAINY = 5'd3;
    localparam logic [4:0] MDATAOUT = 5'd4;
    localparam logic [4:0] ADATAOUT = 5'd5;
    localparam logic [4:0] DCONFIG  = 5'd6;
    localparam logic [4:0] ACONFIG  = 5'd7;
    localparam logic [4:0] STATUS   = 5'd30;
    localparam logic [4:0] IP_ID    = 5'd31;

    localparam int MASK_LSB = 16;
    localparam int BUSY_BIT = 8;
    localparam int DONE_BIT = 0;
    localparam int ERR_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } aip_state_e;

    function automatic logic code_is_defined(input logic [4:0] code);
        return (code <= ACONFIG) || (code == STATUS) || (code == IP_ID);
    endfunction

endpackage : aip_pkg
`default_nettype wire

// File: rtl/aip_ptr_counter.sv
`default_nettype none
// ============================================================================
// Module      : aip_ptr_counter
// Description : Loadable auto-increment address pointer wrapping at DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module aip_ptr_counter #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_a,
    input  logic          en,
    input  logic          load,
    input  logic          inc,
    input  logic [AW-1:0] load_val,
    output logic [AW-1:0] ptr
);

    localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

    logic [AW-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_ptr <= '0;
        end else if (en) begin
            if (load) begin
                r_ptr <= load_val;
            end else if (inc) begin
                r_ptr <= (r_ptr == C_LAST) ? '0 : r_ptr + 1'b1;
            end
        end
    end

    assign ptr = r_ptr;

endmodule : aip_ptr_counter
`default_nettype wire

// File: rtl/aip_host_responder.sv
`default_nettype none
// ============================================================================
// Module      : aip_host_responder
// Description : AIP host-bus responder: config decode, memory pointers,
//               status/interrupt, config register and core start/done FSM.
//               Optional macro AIP_ERR_FLAG_EN enables the ERR flag (bit 1).
// Revision    : 1.0 - initial release
// ============================================================================
module aip_host_responder
    import aip_pkg::*;
#(
    parameter int          DATAWIDTH   = 32,
    parameter logic [31:0] IP_ID_VALUE = 32'h1000500A,
    parameter int          X_DEPTH     = 32,
    parameter int          Y_DEPTH     = 32,
    parameter int          Z_DEPTH     = 64
) (
    input  logic                       clk,
    input  logic                       rst_a,
    input  logic                       en_s,
    input  logic [DATAWIDTH-1:0]       data_in,
    output logic [DATAWIDTH-1:0]       data_out,
    input  logic                       write,
    input  logic                       read,
    input  logic                       start,
    input  logic [4:0]                 conf_dbus,
    output logic                       int_req,
    output logic                       x_we,
    output logic [$clog2(X_DEPTH)-1:0] x_addr,
    output logic                       y_we,
    output logic [$clog2(Y_DEPTH)-1:0] y_addr,
    output logic [DATAWIDTH-1:0]       mem_wdata,
    output logic [$clog2(Z_DEPTH)-1:0] z_addr,
    input  logic [DATAWIDTH-1:0]       z_rdata,
    output logic [DATAWIDTH-1:0]       cfg,
    output logic                       core_start,
    input  logic                       core_done
);

    localparam int AW_X = $clog2(X_DEPTH);
    localparam int AW_Y = $clog2(Y_DEPTH);
    localparam int AW_Z = $clog2(Z_DEPTH);

    aip_state_e          r_state;
    logic                r_core_start;
    logic [DATAWIDTH-1:0] r_dout;
    logic [DATAWIDTH-1:0] r_cfg;
    logic [7:0]          r_mask;
    logic [7:0]          r_flags;
    logic                r_int_n;

    logic                w_wr;
    logic                w_rd;
    logic                w_busy;
    logic                w_done_evt;
    logic                w_err_evt;
    logic                w_x_we;
    logic                w_y_we;
    logic [AW_X-1:0]     w_x_ptr;
    logic [AW_Y-1:0]     w_y_ptr;
    logic [AW_Z-1:0]     w_z_ptr;
    logic [7:0]          w_flags_nxt;
    logic [31:0]         w_status;
    logic [DATAWIDTH-1:0] w_rd_word;

    // A simultaneous read is dropped when write is also asserted.
    assign w_wr       = en_s & write;
    assign w_rd       = en_s & read & ~write;
    assign w_busy     = (r_state != ST_IDLE);
    assign w_done_evt = en_s & core_done & (r_state == ST_BUSY);
    assign w_x_we     = w_wr & (conf_dbus == MDATAINX);
    assign w_y_we     = w_wr & (conf_dbus == MDATAINY);

`ifdef AIP_ERR_FLAG_EN
    assign w_err_evt = ((w_wr | w_rd) & ~code_is_defined(conf_dbus))
                     | (en_s & start & w_busy);
`else
    assign w_err_evt = 1'b0;
`endif

    aip_ptr_counter #(.DEPTH(X_DEPTH), .AW(AW_X)) u_x_ptr (
        .clk      (clk),
        .rst_a    (rst_a),
        .en       (en_s),
        .load     (w_wr && (conf_dbus == ADATAINX)),
        .inc      (w_x_we),
        .load_val (data_in[AW_X-1:0]),
        .ptr      (w_x_ptr)
    );

    aip_ptr_counter #(.DEPTH(Y_DEPTH), .AW(AW_Y)) u_y_ptr (
        .clk      (clk),
        .rst_a    (rst_a),
        .en       (en_s),
        .load     (w_wr && (conf_dbus == ADATAINY)),
        .inc      (w_y_we),
        .load_val (data_in[AW_Y-1:0]),
        .ptr      (w_y_ptr)
    );

    aip_ptr_counter #(.DEPTH(Z_DEPTH), .AW(AW_Z)) u_z_ptr (
        .clk      (clk),
        .rst_a    (rst_a),
        .en       (en_s),
        .load     (w_wr && (conf_dbus == ADATAOUT)),
        .inc      (w_rd && (conf_dbus == MDATAOUT)),
        .load_val (data_in[AW_Z-1:0]),
        .ptr      (w_z_ptr)
    );

    // Done/err set after the host clear so a same-cycle set always wins.
    always_comb begin
        w_flags_nxt = r_flags;
        if (w_wr && (conf_dbus == STATUS)) begin
            w_flags_nxt = r_flags & ~data_in[7:0];
        end
        if (w_done_evt) begin
            w_flags_nxt[DONE_BIT] = 1'b1;
        end
        if (w_err_evt) begin
            w_flags_nxt[ERR_BIT] = 1'b1;
        end
    end

    always_comb begin
        w_status                   = '0;
        w_status[MASK_LSB +: 8]    = r_mask;
        w_status[BUSY_BIT]         = w_busy;
        w_status[7:0]              = r_flags;
    end

    always_comb begin
        w_rd_word = '0;
        case (conf_dbus)
            STATUS:   w_rd_word = DATAWIDTH'(w_status);
            IP_ID:    w_rd_word = DATAWIDTH'(IP_ID_VALUE);
            DCONFIG:  w_rd_word = r_cfg;
            MDATAOUT: w_rd_word = z_rdata;
            default:  w_rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_state      <= ST_IDLE;
            r_core_start <= 1'b0;
        end else if (en_s) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_START;
                        r_core_start <= 1'b1;
                    end
                end
                ST_START: begin
                    r_state      <= ST_BUSY;
                    r_core_start <= 1'b0;
                end
                ST_BUSY: begin
                    if (core_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_core_start <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_dout  <= '0;
            r_cfg   <= '0;
            r_mask  <= '0;
            r_flags <= '0;
            r_int_n <= 1'b1;
        end else if (en_s) begin
            if (w_wr && (conf_dbus == DCONFIG)) begin
                r_cfg <= data_in;
            end
            if (w_wr && (conf_dbus == STATUS)) begin
                r_mask <= data_in[MASK_LSB +: 8];
            end
            r_flags <= w_flags_nxt;
            // Built from the registered flags/mask: lags a change by one cycle.
            r_int_n <= ~|(r_flags & r_mask);
            if (w_rd) begin
                r_dout <= w_rd_word;
            end
        end
    end

    assign data_out   = r_dout;
    assign int_req    = r_int_n;
    assign cfg        = r_cfg;
    assign core_start = r_core_start;
    assign x_we       = w_x_we;
    assign y_we       = w_y_we;
    assign x_addr     = w_x_ptr;
    assign y_addr     = w_y_ptr;
    assign z_addr     = w_z_ptr;
    assign mem_wdata  = data_in;

endmodule : aip_host_responder
`default_nettype wire

// File: tb/tb_aip_host_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_aip_host_responder
// Description : Self-checking bench for aip_host_responder with a
//               behavioural register/pointer model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_aip_host_responder;

    localparam logic [31:0] C_IP_ID = 32'h1000500A;
    localparam logic [4:0] MDATAINX = 5'd0, ADATAINX = 5'd1, MDATAINY = 5'd2,
                           ADATAINY = 5'd3, MDATAOUT = 5'd4, ADATAOUT = 5'd5,
                           DCONFIG  = 5'd6, STATUS   = 5'd30, IP_ID = 5'd31;
`ifdef AIP_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_a, en_s, write, read, start, core_done;
    logic [31:0] data_in, data_out, mem_wdata, z_rdata, cfg;
    logic [4:0]  conf_dbus, x_addr, y_addr;
    logic [5:0]  z_addr;
    logic        int_req, x_we, y_we, core_start;

    logic [31:0] zmem [64];
    assign z_rdata = zmem[z_addr];

    always #5 clk = ~clk;

    aip_host_responder dut (
        .clk(clk), .rst_a(rst_a), .en_s(en_s), .data_in(data_in),
        .data_out(data_out), .write(write), .read(read), .start(start),
        .conf_dbus(conf_dbus), .int_req(int_req), .x_we(x_we), .x_addr(x_addr),
        .y_we(y_we), .y_addr(y_addr), .mem_wdata(mem_wdata), .z_addr(z_addr),
        .z_rdata(z_rdata), .cfg(cfg), .core_start(core_start),
        .core_done(core_done)
    );

    int checks = 0;
    int errors = 0;
    int cs_count = 0;

    // Behavioural model of host-visible state.
    int          m_x, m_y, m_z;
    logic [31:0] m_cfg, m_dout;
    logic [7:0]  m_mask, m_flags;
    bit          m_busy;

    always @(negedge clk) if (core_start === 1'b1) cs_count++;

    function automatic logic [31:0] exp_status();
        return (32'(m_mask) << 16) | (m_busy ? 32'h100 : 32'h0) | 32'(m_flags);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [4:0] code, input logic [31:0] d);
        conf_dbus = code; data_in = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic host_read(input logic [4:0] code, output logic [31:0] q);
        conf_dbus = code; read = 1'b1;
        tick();
        read = 1'b0;
        q = data_out;
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_z = 0; m_cfg = 0; m_dout = 0;
        m_mask = 0; m_flags = 0; m_busy = 0;
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        repeat (3) tick();
        checks++;
        if ({data_out, int_req, cfg, core_start, x_addr, y_addr, z_addr} !==
            {32'd0, 1'b1, 32'd0, 1'b0, 5'd0, 5'd0, 6'd0}) begin
            errors++;
            $display("FAIL reset_values: dout=%h int=%b cfg=%h cs=%b xa=%0d ya=%0d za=%0d, want 0/1/0/0/0/0/0",
                     data_out, int_req, cfg, core_start, x_addr, y_addr, z_addr);
        end
        #2 rst_a = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic test_ip_id_status();
        logic [31:0] q;
        host_read(IP_ID, q);
        checks++;
        if (q !== C_IP_ID) begin errors++; $display("FAIL ip_id: got %h want %h", q, C_IP_ID); end
        host_read(STATUS, q);
        checks++;
        if (q !== 32'd0 || int_req !== 1'b1) begin
            errors++; $display("FAIL status_after_reset: got %h int=%b want 0 int=1", q, int_req);
        end
        m_dout = q;
    endtask

    task automatic test_x_writes();
        host_write(ADATAINX, 32'd0); m_x = 0;
        for (int i = 1; i <= 10; i++) begin
            conf_dbus = MDATAINX; data_in = i; write = 1'b1;
            #1;
            checks++;
            if (x_we !== 1'b1 || x_addr !== 5'(m_x) || mem_wdata !== 32'(i) || y_we !== 1'b0) begin
                errors++;
                $display("FAIL x_write_%0d: we=%b addr=%0d wd=%0d yw=%b want 1/%0d/%0d/0",
                         i, x_we, x_addr, mem_wdata, y_we, m_x, i);
            end
            tick(); write = 1'b0;
            m_x = (m_x + 1) % 32;
        end
        checks++;
        if (x_addr !== 5'd10) begin errors++; $display("FAIL x_ptr_final: got %0d want 10", x_addr); end
        host_write(ADATAINX, 32'd30); m_x = 30;
        for (int i = 0; i < 3; i++) begin
            conf_dbus = MDATAINX; data_in = 32'h100 + i; write = 1'b1;
            #1;
            checks++;
            if (x_we !== 1'b1 || x_addr !== 5'(m_x)) begin
                errors++; $display("FAIL x_wrap_%0d: we=%b addr=%0d want 1/%0d", i, x_we, x_addr, m_x);
            end
            tick(); write = 1'b0;
            m_x = (m_x + 1) % 32;
        end
        // Frozen when disabled: no write enable, no pointer movement.
        en_s = 1'b0; conf_dbus = MDATAINX; write = 1'b1;
        #1;
        checks++;
        if (x_we !== 1'b0) begin errors++; $display("FAIL x_we_disabled: got %b want 0", x_we); end
        tick(); write = 1'b0; en_s = 1'b1;
        checks++;
        if (x_addr !== 5'(m_x)) begin errors++; $display("FAIL x_ptr_disabled: got %0d want %0d", x_addr, m_x); end
    endtask

    task automatic test_config();
        logic [31:0] q;
        host_write(DCONFIG, 32'h0000_00AA); m_cfg = 32'hAA;
        checks++;
        if (cfg !== 32'hAA) begin errors++; $display("FAIL cfg_write: got %h want aa", cfg); end
        host_read(DCONFIG, q); m_dout = q;
        checks++;
        if (q !== 32'hAA) begin errors++; $display("FAIL cfg_read: got %h want aa", q); end
    endtask

    task automatic test_interrupt();
        logic [31:0] q;
        int base;
        host_write(STATUS, 32'h0001_0000); m_mask = 8'h01;
        base = cs_count;
        start = 1'b1; tick(); start = 1'b0; m_busy = 1;
        checks++;
        if (core_start !== 1'b1) begin errors++; $display("FAIL core_start_high: got %b want 1", core_start); end
        tick();
        checks++;
        if (core_start !== 1'b0) begin errors++; $display("FAIL core_start_low: got %b want 0", core_start); end
        host_read(STATUS, q);
        checks++;
        if (q !== exp_status() || q !== 32'h0001_0100) begin
            errors++; $display("FAIL status_busy: got %h want 00010100", q);
        end
        core_done = 1'b1; tick(); core_done = 1'b0; m_busy = 0; m_flags[0] = 1'b1;
        checks++;
        if (int_req !== 1'b1) begin errors++; $display("FAIL int_lag: got %b want 1", int_req); end
        tick();
        checks++;
        if (int_req !== 1'b0) begin errors++; $display("FAIL int_assert: got %b want 0", int_req); end
        host_read(STATUS, q);
        checks++;
        if (q !== 32'h0001_0001) begin errors++; $display("FAIL status_done: got %h want 00010001", q); end
        checks++;
        if (cs_count - base !== 1) begin errors++; $display("FAIL core_start_cycles: got %0d want 1", cs_count - base); end
        host_write(STATUS, 32'h0001_0001); m_flags = 0;
        tick();
        checks++;
        if (int_req !== 1'b1) begin errors++; $display("FAIL int_clear: got %b want 1", int_req); end
    endtask

    task automatic test_busy_start();
        logic [31:0] q;
        int base;
        base = cs_count;
        start = 1'b1; tick(); start = 1'b0; m_busy = 1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        if (ERR_EN) m_flags[1] = 1'b1;
        tick();
        checks++;
        if (cs_count - base !== 1) begin errors++; $display("FAIL second_start: pulses=%0d want 1", cs_count - base); end
        host_read(STATUS, q);
        checks++;
        if (q !== exp_status()) begin errors++; $display("FAIL status_busy2: got %h want %h", q, exp_status()); end
        // Clear and done on the same edge: done must survive.
        conf_dbus = STATUS; data_in = 32'h0001_0003; write = 1'b1; core_done = 1'b1;
        tick();
        write = 1'b0; core_done = 1'b0;
        m_busy = 0; m_flags = 8'h01;
        host_read(STATUS, q);
        checks++;
        if (q !== 32'h0001_0001) begin errors++; $display("FAIL done_clear_race: got %h want 00010001", q); end
        host_write(STATUS, 32'h0001_0001); m_flags = 0;
        tick();
        checks++;
        if (int_req !== 1'b1) begin errors++; $display("FAIL int_clear2: got %b want 1", int_req); end
    endtask

    task automatic test_z_reads();
        logic [31:0] q;
        for (int i = 0; i < 64; i++) zmem[i] = $urandom;
        host_write(ADATAOUT, 32'd0); m_z = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 7) begin
                en_s = 1'b0; conf_dbus = MDATAOUT; read = 1'b1;
                tick(); tick();
                read = 1'b0; en_s = 1'b1;
                checks++;
                if (data_out !== zmem[6] || z_addr !== 6'd7) begin
                    errors++; $display("FAIL z_freeze: dout=%h za=%0d want %h/7", data_out, z_addr, zmem[6]);
                end
            end
            host_read(MDATAOUT, q);
            checks++;
            if (q !== zmem[m_z]) begin errors++; $display("FAIL z_read_%0d: got %h want %h", i, q, zmem[m_z]); end
            m_z = (m_z + 1) % 64;
            m_dout = q;
        end
        checks++;
        if (z_addr !== 6'd14) begin errors++; $display("FAIL z_ptr_final: got %0d want 14", z_addr); end
    endtask

    task automatic test_random();
        logic [31:0] q, v;
        int op;
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 7);
            v = $urandom;
            case (op)
                0: begin host_write(ADATAINX, v); m_x = int'(v % 32); end
                1: begin host_write(ADATAINY, v); m_y = int'(v % 32); end
                2, 3: begin
                    conf_dbus = (op == 2) ? MDATAINX : MDATAINY; data_in = v; write = 1'b1;
                    #1;
                    checks++;
                    if (op == 2 ? (x_we !== 1'b1 || y_we !== 1'b0 || x_addr !== 5'(m_x))
                                : (y_we !== 1'b1 || x_we !== 1'b0 || y_addr !== 5'(m_y)) ||
                        mem_wdata !== v) begin
                        errors++;
                        $display("FAIL rnd_mem_write it=%0d: xw=%b yw=%b xa=%0d ya=%0d want ptr x=%0d y=%0d",
                                 it, x_we, y_we, x_addr, y_addr, m_x, m_y);
                    end
                    tick(); write = 1'b0;
                    if (op == 2) m_x = (m_x + 1) % 32; else m_y = (m_y + 1) % 32;
                end
                4: begin
                    host_write(DCONFIG, v); m_cfg = v;
                    checks++;
                    if (cfg !== m_cfg) begin errors++; $display("FAIL rnd_cfg it=%0d: got %h want %h", it, cfg, m_cfg); end
                end
                5: begin
                    host_read(DCONFIG, q); m_dout = m_cfg;
                    checks++;
                    if (q !== m_dout) begin errors++; $display("FAIL rnd_cfg_read it=%0d: got %h want %h", it, q, m_dout); end
                end
                6: begin
                    conf_dbus = DCONFIG; data_in = v; write = 1'b1; read = 1'b1;
                    tick(); write = 1'b0; read = 1'b0; m_cfg = v;
                    checks++;
                    if (data_out !== m_dout || cfg !== m_cfg) begin
                        errors++; $display("FAIL rnd_wr_rd it=%0d: dout=%h cfg=%h want %h/%h", it, data_out, cfg, m_dout, m_cfg);
                    end
                end
                default: begin
                    host_read(5'($urandom_range(8, 29)), q); m_dout = 32'd0;
                    if (ERR_EN) m_flags[1] = 1'b1;
                    checks++;
                    if (q !== 32'd0) begin errors++; $display("FAIL rnd_undef_read it=%0d: got %h want 0", it, q); end
                end
            endcase
            checks++;
            if (x_addr !== 5'(m_x) || y_addr !== 5'(m_y)) begin
                errors++; $display("FAIL rnd_ptrs it=%0d: x=%0d y=%0d want %0d/%0d", it, x_addr, y_addr, m_x, m_y);
            end
        end
        host_read(STATUS, q);
        checks++;
        if (q !== exp_status()) begin errors++; $display("FAIL rnd_status: got %h want %h", q, exp_status()); end
        host_write(STATUS, 32'h0001_00FF); m_flags = 0;
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] q;
        host_write(DCONFIG, 32'h55); m_cfg = 32'h55;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        rst_a = 1'b0;
        #1;
        checks++;
        if (cfg !== 32'd0 || core_start !== 1'b0 || int_req !== 1'b1) begin
            errors++; $display("FAIL async_reset: cfg=%h cs=%b int=%b want 0/0/1", cfg, core_start, int_req);
        end
        #1 rst_a = 1'b1;
        model_reset();
        core_done = 1'b1; tick(); core_done = 1'b0;
        host_read(STATUS, q);
        checks++;
        if (q !== 32'd0 || int_req !== 1'b1) begin
            errors++; $display("FAIL done_after_reset: status=%h int=%b want 0/1", q, int_req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        en_s = 1'b1; write = 1'b0; read = 1'b0; start = 1'b0; core_done = 1'b0;
        conf_dbus = 5'd0; data_in = 32'd0; rst_a = 1'b0;
        for (int i = 0; i < 64; i++) zmem[i] = 32'd0;
        model_reset();
        test_reset();
        test_ip_id_status();
        test_x_writes();
        test_config();
        test_interrupt();
        test_busy_start();
        test_z_reads();
        test_random();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_aip_host_responder
`default_nettype wire

// File: doc/aip_host_responder.md
Name: aip_host_responder

Overview:
- IP-side responder for the AIP host bus (config code / write / read / start).
- Decodes config codes and holds the per-memory auto-increment pointers, the status/interrupt register and the config register.
- Drives memory ports and a start pulse toward the computation core.
- Collects the core's done pulse and raises the active-low interrupt. Sits between the SoC AIP wrapper and the convolution datapath.

Parameters:
- DATAWIDTH, 32, AIP data bus width.
- IP_ID_VALUE, 32'h1000500A, constant returned on IP_ID reads.
- X_DEPTH, 32, words in input memory X.
- Y_DEPTH, 32, words in input memory Y.
- Z_DEPTH, 64, words in output memory Z.

Ports:
- clk  in  1  system clock, rising edge.
- rst_a  in  1  asynchronous active-low reset.
- en_s  in  1  synchronous enable; 0 freezes all state.
- data_in  in  DATAWIDTH  host write data.
- data_out  out  DATAWIDTH  host read data, registered.
- write  in  1  host write strobe, one word per cycle.
- read  in  1  host read strobe, one word per cycle.
- start  in  1  host start strobe.
- conf_dbus  in  5  config code.
- int_req  out  1  interrupt, active-low.
- x_we  out  1  memory X write enable.
- x_addr  out  $clog2(X_DEPTH)  memory X write address.
- y_we  out  1  memory Y write enable.
- y_addr  out  $clog2(Y_DEPTH)  memory Y write address.
- mem_wdata  out  DATAWIDTH  shared write data (data_in pass-through).
- z_addr  out  $clog2(Z_DEPTH)  memory Z read address (async-read memory).
- z_rdata  in  DATAWIDTH  memory Z read data.
- cfg  out  DATAWIDTH  config register (core uses [9:5]=sizeY, [4:0]=sizeX).
- core_start  out  1  one-cycle start pulse to core.
- core_done  in  1  one-cycle completion pulse from core.

Behaviour:
- Clock and reset: one clock (clk); reset rst_a is asynchronous, active-low.
- Reset values: data_out=0, int_req=1, all pointers=0, cfg=0, mask=0, flags=0, core_start=0, FSM=IDLE.
- en_s gating: all registers update only when en_s=1. en_s=0 ignores strobes; x_we/y_we are forced 0.
- Config codes: 0 MDATAINX, 1 ADATAINX, 2 MDATAINY, 3 ADATAINY, 4 MDATAOUT, 5 ADATAOUT, 6 DCONFIG, 7 ACONFIG, 30 STATUS, 31 IP_ID.
- Write to an A* code: load the matching pointer with data_in[AW-1:0]. ACONFIG write is accepted and ignored (single register).
- Write to MDATAINX/MDATAINY (combinational, same cycle): x_we/y_we=write, addr=pointer, mem_wdata=data_in. Pointer then increments on the edge.
- Write to DCONFIG: cfg<=data_in.
- Write to STATUS: mask<=data_in[23:16]; flags<=flags & ~data_in[7:0].
- Read: on an edge with read=1, data_out<=selected word.
  - STATUS = {8'd0, mask, 7'd0, busy, flags}.
  - IP_ID = IP_ID_VALUE.
  - DCONFIG = cfg.
  - MDATAOUT = z_rdata at z_addr = Z pointer; the Z pointer then increments.
  - Other codes return 0.
- data_out holds its value between reads. Read latency is 1 edge.
- Pointer wrap: pointers increment modulo depth (X pointer 31 -> 0).
- write and read both high: write takes priority and the read is ignored.
- FSM IDLE -> START on start=1. START lasts 1 cycle with core_start=1, then goes to BUSY. BUSY -> IDLE on core_done=1, which sets flags[0].
- start while in START/BUSY is ignored.
- Same-cycle core_done and STATUS clear of bit0: set wins.
- busy = (state != IDLE).
- int_req = ~|(flags & mask), registered, updates the cycle after a flag or mask change.
- Reset mid-BUSY returns to IDLE; a later core_done is ignored because the FSM is not in BUSY.

Optional Feature:
- AIP_ERR_FLAG_EN defined: flags[1] (ERR) is set by any write/read to an undefined code or by start while busy. ERR is cleared like other flags and can assert int_req when mask[1]=1.
- Undefined: flags[1] is constant 0 and these events are silently ignored.

Decomposition:
- aip_pkg: config code localparams, STATUS field positions (MASK_LSB=16, BUSY_BIT=8, DONE_BIT=0, ERR_BIT=1), FSM state enum.
- Sub-module aip_ptr_counter (load/increment/wrap, parameterised depth), instantiated for X, Y and Z.

Test Plan:
- Reset, then read IP_ID and STATUS -> data_out=IP_ID_VALUE, STATUS=0, int_req=1.
- Write ADATAINX=0, then 10 MDATAINX writes 1..10 -> x_we pulses with x_addr 0..9, final X pointer=10. Write ADATAINX=30 plus 3 writes -> addresses 30, 31, 0.
- Write DCONFIG=0x000000AA -> cfg=0xAA, and a DCONFIG read returns 0xAA.
- Enable mask bit0, start, then core_done pulse -> core_start high exactly 1 cycle, busy read=1 before done, int_req=0 one cycle after done, STATUS=0x00010001. Clear with 0x00010001 -> int_req=1.
- Second start while BUSY -> no second core_start. Same-cycle core_done and clear -> flags[0]=1.
- Write ADATAOUT=0, then 14 MDATAOUT reads with z_rdata=mem[addr] -> data_out sequence mem[0..13], z_addr ends at 14. en_s=0 mid-burst -> pointer and data_out frozen.
